// File: rtl/module_calc_ctrl.sv
// module_calc_ctrl
// Two-operand key-entry controller with a sequential restoring divider.
// The user enters dividend A, then divisor B; the block divides A by B
// one quotient bit per clock and then shows the result until the next key.
//
// Ports
//   clk       sole clock, rising edge
//   reset     synchronous, active-high reset
//   press     single-cycle key-accepted pulse
//   numero    key value, valid while press=1
//   a_q, b_q  stored dividend / divisor
//   q, r      quotient / remainder of the last completed division
//   busy      high while dividing
//   done      one-cycle pulse after a result is written
//   div0      divide-by-zero flag for the last result
//   sel_disp  0 = show operands, 1 = show result
//
// Configuration
//   CALC_CTRL_DIV0_EN  when defined, a zero divisor bypasses the iterations
//                      and writes the result (with div0=1) on the first
//                      DIVIDE cycle. When undefined, div0 stays 0 and a zero
//                      divisor runs the normal iterations, which naturally
//                      give q = all ones and r = A.

module module_calc_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             press,
   input  logic [WIDTH-1:0] numero,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic             sel_disp
);

   // Counter runs 0..WIDTH-1; keep at least one bit for WIDTH=1.
   localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      DIVIDE = 2'd2,
      SHOW   = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   // Partial remainder is always below the divisor (or equal to a dividend
   // prefix when dividing by zero), so WIDTH bits hold it between steps;
   // the WIDTH+1-bit working value lives inside div_step.
   logic [WIDTH-1:0] rem_r, rem_s;
   // Shift register: dividend bits leave at the MSB, quotient bits enter at the LSB.
   logic [WIDTH-1:0] sh_r, sh_s;
   logic [WIDTH-1:0] a_s, b_s, q_s, r_s;
   logic             done_s, div0_s;
   logic             div0_skip_s;
   logic [2*WIDTH-1:0] step_s;

   // One restoring-division iteration. Returns {next remainder, next shift register}.
   function automatic logic [2*WIDTH-1:0] div_step(
      input logic [WIDTH-1:0] rem,
      input logic [WIDTH-1:0] sh,
      input logic [WIDTH-1:0] dvs
   );
      logic [WIDTH:0]   trial;
      logic [WIDTH:0]   diff;
      logic [WIDTH-1:0] sh_n;
      logic             qbit;
      trial   = {rem, sh[WIDTH-1]};
      diff    = trial - {1'b0, dvs};
      // A set MSB is the borrow: trial < divisor, so restore.
      qbit    = ~diff[WIDTH];
      sh_n    = sh << 1;
      sh_n[0] = qbit;
      if (qbit) begin
         div_step = {diff[WIDTH-1:0], sh_n};
      end else begin
         div_step = {trial[WIDTH-1:0], sh_n};
      end
   endfunction

`ifdef CALC_CTRL_DIV0_EN
   // Zero divisor detected on the first DIVIDE cycle takes the fast path.
   assign div0_skip_s = (cnt_r == {CW{1'b0}}) && (b_q == {WIDTH{1'b0}});
`else
   assign div0_skip_s = 1'b0;
`endif

   assign step_s = div_step(rem_r, sh_r, b_q);

   // Next-state and next-datapath logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      rem_s   = rem_r;
      sh_s    = sh_r;
      a_s     = a_q;
      b_s     = b_q;
      q_s     = q;
      r_s     = r;
      div0_s  = div0;
      done_s  = 1'b0;
      case (state_r)
         WAIT_A: begin
            if (press) begin
               a_s     = numero;
               state_s = WAIT_B;
            end else begin
               state_s = WAIT_A;
            end
         end
         WAIT_B: begin
            if (press) begin
               b_s     = numero;
               cnt_s   = {CW{1'b0}};
               rem_s   = {WIDTH{1'b0}};
               sh_s    = a_q;
               state_s = DIVIDE;
            end else begin
               state_s = WAIT_B;
            end
         end
         DIVIDE: begin
            // press is deliberately not looked at here.
            if (div0_skip_s) begin
               q_s     = {WIDTH{1'b1}};
               r_s     = a_q;
               div0_s  = 1'b1;
               done_s  = 1'b1;
               state_s = SHOW;
            end else begin
               rem_s = step_s[2*WIDTH-1:WIDTH];
               sh_s  = step_s[WIDTH-1:0];
               if (cnt_r == LAST_CNT) begin
                  q_s     = step_s[WIDTH-1:0];
                  r_s     = step_s[2*WIDTH-1:WIDTH];
                  div0_s  = 1'b0;
                  done_s  = 1'b1;
                  state_s = SHOW;
               end else begin
                  cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  state_s = DIVIDE;
               end
            end
         end
         SHOW: begin
            if (press) begin
               a_s     = numero;
               b_s     = {WIDTH{1'b0}};
               q_s     = {WIDTH{1'b0}};
               r_s     = {WIDTH{1'b0}};
               div0_s  = 1'b0;
               state_s = WAIT_B;
            end else begin
               state_s = SHOW;
            end
         end
         default: begin
            state_s = WAIT_A;
         end
      endcase
   end

   // State and datapath registers; status outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= WAIT_A;
         cnt_r    <= {CW{1'b0}};
         rem_r    <= {WIDTH{1'b0}};
         sh_r     <= {WIDTH{1'b0}};
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         q        <= {WIDTH{1'b0}};
         r        <= {WIDTH{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
         div0     <= 1'b0;
         sel_disp <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         rem_r    <= rem_s;
         sh_r     <= sh_s;
         a_q      <= a_s;
         b_q      <= b_s;
         q        <= q_s;
         r        <= r_s;
         busy     <= (state_s == DIVIDE);
         done     <= done_s;
         div0     <= div0_s;
         sel_disp <= (state_s == SHOW);
      end
   end

endmodule
